dcache_ctrl: RTL and testbench



---
 rtl/dcache_ctrl.sv | 158 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the
// MEM stage. A hit completes with zero latency. A miss stalls the pipeline
// while the victim line is written back (if it is dirty) and the requested
// line is refilled. The access is then looked up again and hits.
module dcache_ctrl #(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 22   // must equal 32 - INDEX_W - 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    input  logic         p1_MemRead_i,
    input  logic         p1_MemWrite_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [255:0] mem_data_o,
    output logic [31:0]  mem_addr_o,
    output logic         mem_enable_o,
    output logic         mem_write_o
);

    localparam int LINES = 1 << INDEX_W;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] MISS      = 3'd1;
    localparam logic [2:0] WRITEBACK = 3'd2;
    localparam logic [2:0] ALLOCATE  = 3'd3;
    localparam logic [2:0] REFILL    = 3'd4;

    logic [2:0]         state;
    logic [255:0]       data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]   valid;
    logic [LINES-1:0]   dirty;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] idx;
    logic [2:0]         word;
    logic [255:0]       cur_line;
    logic [TAG_W-1:0]   victim_tag;
    logic               req;
    logic               hit;
    logic               ack;
    logic               store_hit;
    logic               refill_done;
    logic               unused_addr;

    // Address split. The byte offset within a word is not used.
    assign req_tag     = p1_addr_i[31:32-TAG_W];
    assign idx         = p1_addr_i[4+INDEX_W:5];
    assign word        = p1_addr_i[4:2];
    assign unused_addr = ^p1_addr_i[1:0];

    assign cur_line    = data_mem[idx];
    assign victim_tag  = tag_mem[idx];
    assign req         = p1_MemRead_i | p1_MemWrite_i;
    assign hit         = valid[idx] & (victim_tag == req_tag);

    // An ack counts only while a request is actually on the bus. A stray
    // pulse in IDLE, MISS, REFILL or the first WRITEBACK/ALLOCATE cycle
    // is ignored.
    assign ack         = mem_ack_i & mem_enable_o;

    // When both MemRead and MemWrite are high, the access is a store.
    assign store_hit   = (state == IDLE) & p1_MemWrite_i & hit;
    assign refill_done = (state == ALLOCATE) & ack;

    // The stall is released while reset is held, so upstream is never frozen by a dead FSM.
    assign p1_stall_o  = rst_i & (((state == IDLE) & req & ~hit) | (state != IDLE));

    // Zero-latency read of the selected word on a load hit.
    always_comb begin
        // NOTE: default first so every path assigns p1_data_o and no latch is inferred.
        p1_data_o = '0;
        if ((state == IDLE) && p1_MemRead_i && hit) begin
            p1_data_o = cur_line[{word, 5'b0} +: 32];
        end
    end

    // Data/tag arrays: the refill writes a whole line, and a store hit merges one word.
    // NOTE: the arrays have no reset. valid[] guards them, and a reset port
    // here would prevent mapping onto RAM.
    always_ff @(posedge clk_i) begin
        if (refill_done) begin
            data_mem[idx] <= mem_data_i;
            tag_mem[idx]  <= req_tag;
        end else if (store_hit) begin
            data_mem[idx][{word, 5'b0} +: 32] <= p1_data_i;
        end
    end

    // Miss FSM, valid/dirty bits and the registered memory interface.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples pre-edge values.
            state        <= IDLE;
            valid        <= '0;
            dirty        <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        state <= MISS;
                    end else if (store_hit) begin
                        dirty[idx] <= 1'b1;
                    end
                end
                MISS: begin
                    if (valid[idx] && dirty[idx]) begin
                        state       <= WRITEBACK;
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= {victim_tag, idx, 5'b0};
                        mem_data_o  <= cur_line;
                    end else begin
                        state       <= ALLOCATE;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {req_tag, idx, 5'b0};
                    end
                end
                WRITEBACK: begin
                    if (ack) begin
                        state        <= ALLOCATE;
                        mem_enable_o <= 1'b0;
                        mem_write_o  <= 1'b0;
                        mem_addr_o   <= {req_tag, idx, 5'b0};
                    end else begin
                        mem_enable_o <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (ack) begin
                        state        <= REFILL;
                        mem_enable_o <= 1'b0;
                        valid[idx]   <= 1'b1;
                        dirty[idx]   <= 1'b0;
                    end else begin
                        mem_enable_o <= 1'b1;
                    end
                end
                REFILL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl. A slow-memory model answers line requests
// after a programmable latency. The driver queues the expected load data and
// the expected memory requests. A monitor compares each load result and each
// new memory request against those queues.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;

    dcache_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } mem_exp_t;

    int           vectors     = 0;
    int           miscompares = 0;
    mem_exp_t     exp_mem [$];
    logic [31:0]  exp_load [$];
    logic [255:0] mem_lines [logic [31:0]];

    int           wb_lat      = 1;
    int           rf_lat      = 1;
    logic         model_ack   = 1'b0;
    logic         stray_ack   = 1'b0;
    logic [255:0] model_rdata = '0;
    logic [255:0] stray_data  = '0;

    assign mem_ack_i  = model_ack | stray_ack;
    assign mem_data_i = stray_ack ? stray_data : model_rdata;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Default memory content: each word is 0xA5 followed by its own byte address.
    function automatic logic [31:0] pat(input logic [31:0] line, input int w);
        return {8'hA5, line[23:0] + 24'(w * 4)};
    endfunction

    function automatic logic [255:0] pat_line(input logic [31:0] line);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat(line, w);
        return l;
    endfunction

    function automatic logic [255:0] set_word(input logic [255:0] l, input int w, input logic [31:0] v);
        logic [255:0] r;
        r = l;
        r[w*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        if (mem_lines.exists(a)) return mem_lines[a];
        return pat_line(a);
    endfunction

    // Memory model. mem_enable_o is high for exactly `lat` cycles; the ack is
    // visible in the last of them.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                model_ack = 1'b0;
                cnt = 0;
            end else if (model_ack) begin
                model_ack = 1'b0;
                cnt = 0;
            end else if (mem_enable_o) begin
                cnt++;
                if (cnt >= (mem_write_o ? wb_lat : rf_lat)) begin
                    if (mem_write_o) mem_lines[mem_addr_o] = mem_data_o;
                    else model_rdata = line_of(mem_addr_o);
                    model_ack = 1'b1;
                end
            end
        end
    end

    // Monitor: completed loads and newly raised memory requests.
    initial begin
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                if (p1_MemRead_i && !p1_MemWrite_i && !p1_stall_o) begin
                    if (exp_load.size() == 0) check("load_unexpected", 256'(exp_load.size()), 256'd1);
                    else check("load_data", p1_data_o, exp_load.pop_front());
                end
                if (mem_enable_o && !prev_en) begin
                    if (exp_mem.size() == 0) begin
                        check("mem_unexpected", 256'(exp_mem.size()), 256'd1);
                    end else begin
                        mem_exp_t e;
                        e = exp_mem.pop_front();
                        check("mem_write", mem_write_o, e.wr);
                        check("mem_addr", mem_addr_o, e.addr);
                        if (e.wr) check("mem_wb_data", mem_data_o, e.data);
                    end
                end
            end
            prev_en = mem_enable_o;
        end
    end

    task automatic push_mem(input logic wr, input logic [31:0] a, input logic [255:0] d);
        mem_exp_t e;
        e.wr = wr;
        e.addr = a;
        e.data = d;
        exp_mem.push_back(e);
    endtask

    // One access: called #1 after a rising edge. It returns #1 after the edge at
    // which the access completes. exp_stall counts every stalled cycle,
    // including the cycle of the request itself.
    task automatic access(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic rd, input logic wr, input logic [31:0] exp_rd,
                          input int exp_stall);
        int   n;
        logic first;
        n = 0;
        p1_addr_i     = a;
        p1_data_i     = d;
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        if (rd && !wr) exp_load.push_back(exp_rd);
        @(negedge clk_i);
        first = p1_stall_o;
        while (p1_stall_o && n < 300) begin
            n++;
            @(negedge clk_i);
        end
        check({name, "_stall_first"}, first, exp_stall > 0);
        check({name, "_stall_cycles"}, n, exp_stall);
        @(posedge clk_i);
        #1;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    // Stall length of a miss: request cycle + MISS + (1 idle + L) per memory
    // phase + REFILL.
    function automatic int clean_miss(input int lr);
        return 4 + lr;
    endfunction

    function automatic int dirty_miss(input int lw, input int lr);
        return 5 + lw + lr;
    endfunction

    initial begin
        logic [255:0] l400;
        l400 = set_word(pat_line(32'h400), 1, 32'hDEAD_BEEF);
        mem_lines[32'h400]  = l400;
        mem_lines[32'h1000] = '0;

        rst_i = 1'b0;
        p1_addr_i = '0;
        p1_data_i = '0;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_enable", mem_enable_o, 1'b0);
        check("rst_write", mem_write_o, 1'b0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_data", mem_data_o, 256'h0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("idle_stall", p1_stall_o, 1'b0);
        check("idle_rdata", p1_data_o, 32'h0);

        // Clean miss on a load, then a back-to-back hit on the same line.
        rf_lat = 10;
        push_mem(1'b0, 32'h400, '0);
        access("ld404_miss", 32'h404, 0, 1, 0, 32'hDEAD_BEEF, clean_miss(10));
        access("ld404_hit", 32'h404, 0, 1, 0, 32'hDEAD_BEEF, 0);

        // Store hit, then load back.
        access("st408_hit", 32'h408, 32'h1234_5678, 0, 1, 0, 0);
        access("ld408_hit", 32'h408, 0, 1, 0, 32'h1234_5678, 0);

        // Dirty eviction: the line at 0x400 is written back and 0x800 is refilled.
        wb_lat = 3;
        rf_lat = 5;
        push_mem(1'b1, 32'h400, set_word(l400, 2, 32'h1234_5678));
        push_mem(1'b0, 32'h800, '0);
        access("ld808_dirty", 32'h808, 0, 1, 0, 32'hA500_0808, dirty_miss(3, 5));

        // Store miss on a clean victim. The store merges into the zero refill line.
        rf_lat = 4;
        push_mem(1'b0, 32'h1000, '0);
        access("st1000_miss", 32'h1000, 32'hCAFE_0001, 0, 1, 0, clean_miss(4));
        access("ld1000_hit", 32'h1000, 0, 1, 0, 32'hCAFE_0001, 0);

        // Evicting it writes back the merged line with the store word at word 0.
        wb_lat = 2;
        rf_lat = 2;
        push_mem(1'b1, 32'h1000, {224'h0, 32'hCAFE_0001});
        push_mem(1'b0, 32'h1400, '0);
        access("ld1400_dirty", 32'h1400, 0, 1, 0, 32'hA500_1400, dirty_miss(2, 2));

        // Read+write together is a store: the word is updated and the line becomes dirty.
        access("rw1404_hit", 32'h1404, 32'h5555_AAAA, 1, 1, 0, 0);
        access("ld1404_hit", 32'h1404, 0, 1, 0, 32'h5555_AAAA, 0);
        wb_lat = 1;
        rf_lat = 1;
        push_mem(1'b1, 32'h1400, set_word(pat_line(32'h1400), 1, 32'h5555_AAAA));
        push_mem(1'b0, 32'h1800, '0);
        access("ld1800_dirty", 32'h1800, 0, 1, 0, 32'hA500_1800, dirty_miss(1, 1));

        // A stray ack in IDLE changes nothing.
        stray_data = '1;
        stray_ack = 1'b1;
        @(posedge clk_i);
        #1;
        stray_ack = 1'b0;
        @(negedge clk_i);
        check("stray_idle_enable", mem_enable_o, 1'b0);
        check("stray_idle_stall", p1_stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        access("ld1800_after_stray", 32'h1800, 0, 1, 0, 32'hA500_1800, 0);

        // Reset during ALLOCATE, before the ack arrives.
        rf_lat = 20;
        push_mem(1'b0, 32'h2000, '0);
        p1_addr_i = 32'h2000;
        p1_MemRead_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("abort_enable", mem_enable_o, 1'b0);
        check("abort_stall", p1_stall_o, 1'b0);
        check("abort_addr", mem_addr_o, 32'h0);
        p1_MemRead_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        stray_ack = 1'b1;
        @(posedge clk_i);
        #1;
        stray_ack = 1'b0;
        @(negedge clk_i);
        check("abort_late_ack_enable", mem_enable_o, 1'b0);
        check("abort_late_ack_stall", p1_stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        rf_lat = 3;
        push_mem(1'b0, 32'h2000, '0);
        access("ld2000_remiss", 32'h2000, 0, 1, 0, 32'hA500_2000, clean_miss(3));

        repeat (3) @(posedge clk_i);
        check("load_q_left", 256'(exp_load.size()), 256'd0);
        check("mem_q_left", 256'(exp_mem.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
